// File: rtl/display_out_ctrl.sv
// Sequential binary-to-BCD controller for the decimal display path (shift-add-3, one bit per cycle).
// Optional leading-zero blanking is enabled by defining OUT_ZERO_BLANK_EN.
module display_out_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             busy,
    output logic             done,
    output logic [3:0]       centena,
    output logic [3:0]       dezena,
    output logic [3:0]       unidade,
    output logic             negative,
    output logic [2:0]       blank
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [11:0]      scratch_q, scratch_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic [3:0]       cen_q, cen_d, dez_q, dez_d, uni_q, uni_d;
    logic             neg_q, neg_d;
    logic             done_q, done_d;
    logic [11:0]      adj;
    logic [11:0]      shifted;

    // Add-3 correction on every BCD nibble before the shift.
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ? scratch_q[gi*4 +: 4] + 4'd3
                                                                : scratch_q[gi*4 +: 4];
    end

    assign shifted = (adj << 1) | {11'd0, mag_q[WIDTH-1]};

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        cen_d     = cen_q;
        dez_d     = dez_q;
        uni_d     = uni_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    sign_d    = wr_data[WIDTH-1];
                    mag_d     = wr_data[WIDTH-1] ? (~wr_data + {{(WIDTH-1){1'b0}}, 1'b1}) : wr_data;
                    scratch_d = 12'd0;
                    cnt_d     = 4'(WIDTH);
                    state_d   = CONV;
                end
            end
            CONV: begin
                scratch_d = shifted;
                mag_d     = mag_q << 1;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    cen_d   = shifted[11:8];
                    dez_d   = shifted[7:4];
                    uni_d   = shifted[3:0];
                    neg_d   = sign_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mag_q     <= '0;
            scratch_q <= 12'd0;
            cnt_q     <= 4'd0;
            sign_q    <= 1'b0;
            cen_q     <= 4'd0;
            dez_q     <= 4'd0;
            uni_q     <= 4'd0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            cen_q     <= cen_d;
            dez_q     <= dez_d;
            uni_q     <= uni_d;
            neg_q     <= neg_d;
            done_q    <= done_d;
        end
    end

`ifdef OUT_ZERO_BLANK_EN
    logic [2:0] blank_q, blank_d;

    always_comb begin
        blank_d = blank_q;
        if (state_q == CONV && cnt_q == 4'd1) begin
            blank_d = {shifted[11:8] == 4'd0, shifted[11:4] == 8'd0, 1'b0};
        end
    end

    // Reset pattern shows a single "0" on the units digit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) blank_q <= 3'b110;
        else          blank_q <= blank_d;
    end

    assign blank = blank_q;
`else
    assign blank = 3'b000;
`endif

    assign wr_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign centena  = cen_q;
    assign dezena   = dez_q;
    assign unidade  = uni_q;
    assign negative = neg_q;

endmodule

// File: tb/tb_display_out_ctrl.sv
// Randomized bench for display_out_ctrl: WIDTH=8 and WIDTH=10 instances checked against a decimal arithmetic model.
module tb_display_out_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v8, v10;
    logic [7:0] d8;
    logic [9:0] d10;
    logic       rdy8, busy8, done8, n8, rdy10, busy10, done10, n10;
    logic [3:0] c8, t8, u8, c10, t10, u10;
    logic [2:0] b8, b10;

    display_out_ctrl #(.WIDTH(8)) u_dut8 (
        .clock(clk), .reset_n(rst_n), .wr_valid(v8), .wr_data(d8),
        .wr_ready(rdy8), .busy(busy8), .done(done8),
        .centena(c8), .dezena(t8), .unidade(u8), .negative(n8), .blank(b8)
    );

    display_out_ctrl #(.WIDTH(10)) u_dut10 (
        .clock(clk), .reset_n(rst_n), .wr_valid(v10), .wr_data(d10),
        .wr_ready(rdy10), .busy(busy10), .done(done10),
        .centena(c10), .dezena(t10), .unidade(u10), .negative(n10), .blank(b10)
    );

    bit sel10 = 1'b0;
    logic       o_rdy, o_busy, o_done, o_neg;
    logic [3:0] o_c, o_t, o_u;
    logic [2:0] o_b;
    assign o_rdy  = sel10 ? rdy10  : rdy8;
    assign o_busy = sel10 ? busy10 : busy8;
    assign o_done = sel10 ? done10 : done8;
    assign o_neg  = sel10 ? n10    : n8;
    assign o_c    = sel10 ? c10    : c8;
    assign o_t    = sel10 ? t10    : t8;
    assign o_u    = sel10 ? u10    : u8;
    assign o_b    = sel10 ? b10    : b8;

    int n_tests = 0;
    int n_fail  = 0;
    int rst_blank;
    int hc[2], ht[2], hu[2], hn[2], hb[2];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: interpret the w-bit pattern as signed, then split |v| into decimal digits.
    task automatic model(input int w, input int val, output int c, output int t,
                         output int u, output int n, output int b);
        int v, m;
        v = val & ((1 << w) - 1);
        if (v >= (1 << (w - 1))) v = v - (1 << w);
        n = (v < 0) ? 1 : 0;
        m = (v < 0) ? -v : v;
        c = m / 100;
        t = (m / 10) % 10;
        u = m % 10;
`ifdef OUT_ZERO_BLANK_EN
        b = ((c == 0) ? 4 : 0) + ((c == 0 && t == 0) ? 2 : 0);
`else
        b = 0;
`endif
    endtask

    task automatic set_valid(input bit w10, input bit v, input int val);
        if (w10) begin v10 = v; d10 = val[9:0]; end
        else     begin v8  = v; d8  = val[7:0]; end
    endtask

    task automatic check_held(input int idx);
        check("held_c", o_c, hc[idx]);
        check("held_t", o_t, ht[idx]);
        check("held_u", o_u, hu[idx]);
        check("held_neg", o_neg, hn[idx]);
        check("held_blank", o_b, hb[idx]);
    endtask

    // Called at a falling edge with the selected DUT idle; when chain is set the
    // requester keeps wr_valid high with next_val so it transfers on the done cycle.
    task automatic convert(input bit w10, input int val, input bit chain, input int next_val);
        int w, n, ec, et, eu, en, eb, idx;
        w   = w10 ? 10 : 8;
        idx = w10 ? 1 : 0;
        sel10 = w10;
        set_valid(w10, 1'b1, val);
        #1;
        check("ready_idle", o_rdy, 1);
        @(posedge clk);
        @(negedge clk);
        set_valid(w10, chain, chain ? next_val : 0);
        n = 0;
        while (!o_done && n < w + 3) begin
            check("busy_conv", o_busy, 1);
            check("ready_conv", o_rdy, 0);
            check_held(idx);
            @(negedge clk);
            n++;
        end
        check("latency", n, w);
        model(w, val, ec, et, eu, en, eb);
        check("centena", o_c, ec);
        check("dezena", o_t, et);
        check("unidade", o_u, eu);
        check("negative", o_neg, en);
        check("blank", o_b, eb);
        check("ready_done", o_rdy, 1);
        check("busy_done", o_busy, 0);
        $display("[TB] W=%0d in=0x%0h -> %0d/%0d/%0d neg=%0d blank=%0d lat=%0d",
                 w, val & ((1 << w) - 1), o_c, o_t, o_u, o_neg, o_b, n);
        hc[idx] = ec; ht[idx] = et; hu[idx] = eu; hn[idx] = en; hb[idx] = eb;
        if (!chain) begin
            @(negedge clk);
            check("done_pulse", o_done, 0);
        end
    endtask

    task automatic clear_held();
        for (int i = 0; i < 2; i++) begin
            hc[i] = 0; ht[i] = 0; hu[i] = 0; hn[i] = 0; hb[i] = rst_blank;
        end
    endtask

    task automatic check_reset_state();
        check("rst_ready", o_rdy, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_c", o_c, 0);
        check("rst_t", o_t, 0);
        check("rst_u", o_u, 0);
        check("rst_neg", o_neg, 0);
        check("rst_blank", o_b, rst_blank);
    endtask

    initial begin
        int cur, nxt;
        bit ch;
`ifdef OUT_ZERO_BLANK_EN
        rst_blank = 6;
`else
        rst_blank = 0;
`endif
        clear_held();
        rst_n = 1'b0;
        v8 = 1'b0; v10 = 1'b0; d8 = '0; d10 = '0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        convert(0, 'h7F, 0, 0);

        // Abort a conversion with an asynchronous reset three cycles in.
        sel10 = 1'b0;
        set_valid(0, 1'b1, 'h7F);
        @(posedge clk);
        @(negedge clk);
        set_valid(0, 1'b0, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        #1;
        check("rst_no_done", o_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_held();

        convert(0, 'h05, 0, 0);
        convert(0, 'h7F, 0, 0);
        convert(0, 'h80, 0, 0);
        convert(0, 'hFF, 0, 0);
        convert(0, 'h10, 1, 'h2A);
        convert(0, 'h2A, 0, 0);
        convert(0, 'h00, 0, 0);

        cur = $urandom_range(0, 255);
        for (int i = 0; i < 40; i++) begin
            nxt = $urandom_range(0, 255);
            ch  = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
            convert(0, cur, ch, nxt);
            cur = nxt;
        end

        convert(1, 'h200, 0, 0);
        convert(1, 'h000, 0, 0);
        convert(1, 'h1FF, 0, 0);
        cur = $urandom_range(0, 1023);
        for (int i = 0; i < 15; i++) begin
            nxt = $urandom_range(0, 1023);
            ch  = (i < 14) ? 1'($urandom_range(0, 1)) : 1'b0;
            convert(1, cur, ch, nxt);
            cur = nxt;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
